input_conditioner: RTL and testbench

- N-channel replacement for the per-button debounce instances at the top level. One instance conditions every button and switch.
- Per channel it provides: a 2-flop synchroniser, a counter-based debouncer, a debounced level, and one-cycle press/release pulses.
- Optional per-channel auto-repeat (typematic) pulse, so held direction buttons can step shapes or colours in core.
- Sits between the raw pins and core, clocked by the pixel clock.

---
 rtl/input_conditioner.sv | 154 +++++++++++++++
 tb/tb_input_conditioner.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// input_conditioner: N-channel raw-pin conditioner on the pixel clock.
// Each channel has a 2-flop synchroniser, a counter debouncer, a debounced
// level and one-cycle press/release pulses. Compile with INPUT_COND_REPEAT_EN
// defined to add a per-channel auto-repeat (typematic) pulse on rep;
// otherwise rep is tied low and rpt_en is ignored.
module input_conditioner #(
   parameter int unsigned N               = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 65536,
   parameter int unsigned REPEAT_DELAY    = 24000000,
   parameter int unsigned REPEAT_PERIOD   = 4000000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] in,
   input  logic [N-1:0] rpt_en,
   output logic [N-1:0] out,
   output logic [N-1:0] ondn,
   output logic [N-1:0] onup,
   output logic [N-1:0] rep
);

   localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [N-1:0]  sync1_q;
   logic [N-1:0]  sync2_q;
   logic [CW-1:0] cnt_q [N];
   logic [CW-1:0] cnt_d [N];
   logic [N-1:0]  out_q;
   logic [N-1:0]  out_d;
   logic [N-1:0]  ondn_q;
   logic [N-1:0]  onup_q;
   logic [N-1:0]  acc_rise;
   logic [N-1:0]  acc_fall;

   // Debounce: count consecutive mismatch cycles, accept the synced level on the last one.
   always_comb begin
      out_d    = out_q;
      acc_rise = '0;
      acc_fall = '0;
      for (int unsigned i = 0; i < N; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != out_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               out_d[i]    = sync2_q[i];
               acc_rise[i] = sync2_q[i];
               acc_fall[i] = ~sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   // Synchroniser, debounce counters, level and edge pulses.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         out_q   <= '0;
         ondn_q  <= '0;
         onup_q  <= '0;
         for (int unsigned i = 0; i < N; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q <= in;
         sync2_q <= sync1_q;
         out_q   <= out_d;
         ondn_q  <= acc_rise;
         onup_q  <= acc_fall;
         for (int unsigned i = 0; i < N; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign out  = out_q;
   assign ondn = ondn_q;
   assign onup = onup_q;

`ifdef INPUT_COND_REPEAT_EN
   localparam int unsigned   RMAX        = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned   RW          = $clog2(RMAX + 1);
   localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      RPT_IDLE,
      RPT_DELAY,
      RPT_PERIOD
   } rpt_state_e;

   rpt_state_e    rst_q [N];
   logic [RW-1:0] rc_q  [N];
   logic [N-1:0]  rep_q;

   // Repeat FSM per channel; rc counts cycles since the last pulse (or since arming).
   always_ff @(posedge clk) begin
      if (!reset) begin
         rep_q <= '0;
         for (int unsigned i = 0; i < N; i++) begin
            rst_q[i] <= RPT_IDLE;
            rc_q[i]  <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < N; i++) begin
            rep_q[i] <= 1'b0;
            rc_q[i]  <= '0;
            if (acc_rise[i]) begin
               // press edge: pulse together with ondn when enabled
               rep_q[i] <= rpt_en[i];
               rst_q[i] <= rpt_en[i] ? RPT_DELAY : RPT_IDLE;
            end else if (!out_q[i] || acc_fall[i] || !rpt_en[i]) begin
               // released, releasing now, or disabled: no pulse, counter cleared
               rst_q[i] <= RPT_IDLE;
            end else begin
               case (rst_q[i])
                  // enable rose while held: arm without a pulse
                  RPT_IDLE: begin
                     rst_q[i] <= RPT_DELAY;
                  end
                  RPT_DELAY: begin
                     if (rc_q[i] == DELAY_LAST) begin
                        rep_q[i] <= 1'b1;
                        rst_q[i] <= RPT_PERIOD;
                     end else begin
                        rc_q[i] <= rc_q[i] + RW'(1);
                     end
                  end
                  RPT_PERIOD: begin
                     if (rc_q[i] == PERIOD_LAST) begin
                        rep_q[i] <= 1'b1;
                     end else begin
                        rc_q[i] <= rc_q[i] + RW'(1);
                     end
                  end
                  default: begin
                     rst_q[i] <= RPT_IDLE;
                  end
               endcase
            end
         end
      end
   end

   assign rep = rep_q;
`else
   logic rpt_en_unused;
   assign rpt_en_unused = ^rpt_en;
   assign rep           = '0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with N=3, DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3. Expected rep follows INPUT_COND_REPEAT_EN.
module tb_input_conditioner;

`ifdef INPUT_COND_REPEAT_EN
   localparam bit REP_ON = 1'b1;
`else
   localparam bit REP_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] raw;
   logic [2:0] ren;
   logic [2:0] dout;
   logic [2:0] dn;
   logic [2:0] up;
   logic [2:0] rp;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   input_conditioner #(
      .N               (3),
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (10),
      .REPEAT_PERIOD   (3)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .in     (raw),
      .rpt_en (ren),
      .out    (dout),
      .ondn   (dn),
      .onup   (up),
      .rep    (rp)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then check all four outputs 1 time unit later.
   task automatic step_chk(input string tag, input int idx,
                           input logic [2:0] eo, input logic [2:0] ed,
                           input logic [2:0] eu, input logic [2:0] er);
      @(posedge clk);
      #1;
      check_eq($sformatf("%s[%0d].out", tag, idx), dout, eo);
      check_eq($sformatf("%s[%0d].ondn", tag, idx), dn, ed);
      check_eq($sformatf("%s[%0d].onup", tag, idx), up, eu);
      check_eq($sformatf("%s[%0d].rep", tag, idx), rp, REP_ON ? er : 3'b000);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit         held;
      int         o;
      logic [2:0] eo, ed, eu, er;

      reset = 1'b0;
      raw   = 3'b000;
      ren   = 3'b000;

      // reset state
      for (int k = 0; k < 2; k++) step_chk("rst", k, 3'b000, 3'b000, 3'b000, 3'b000);
      reset = 1'b1;
      for (int k = 0; k < 3; k++) step_chk("idle", k, 3'b000, 3'b000, 3'b000, 3'b000);

      // glitch on ch0: 3 cycles high must be rejected
      for (int j = 0; j < 12; j++) begin
         raw = (j < 3) ? 3'b001 : 3'b000;
         step_chk("glitch", j, 3'b000, 3'b000, 3'b000, 3'b000);
      end

      // clean press on ch0: out after the 6th edge, single ondn, no repeat (rpt_en=0)
      raw = 3'b001;
      for (int j = 0; j < 8; j++) begin
         eo = (j >= 5) ? 3'b001 : 3'b000;
         ed = (j == 5) ? 3'b001 : 3'b000;
         step_chk("press0", j, eo, ed, 3'b000, 3'b000);
      end

      // ch1 bounce then hold with repeat; release lands on a would-be repeat slot
      ren = 3'b010;
      for (int j = 0; j < 55; j++) begin
         raw[1] = (j < 8) ? (((j / 2) % 2) == 0) : (j < 45);
         o      = j - 13;
         held   = (j >= 13) && (j < 50);
         eo     = {1'b0, held, 1'b1};
         ed     = {1'b0, (j == 13), 1'b0};
         eu     = {1'b0, (j == 50), 1'b0};
         er     = {1'b0, held && ((o == 0) || ((o >= 10) && (((o - 10) % 3) == 0))), 1'b0};
         step_chk("bounce_rpt1", j, eo, ed, eu, er);
      end

      // rpt_en rising while ch0 is held: no immediate pulse, first rep 10 cycles later
      ren = 3'b001;
      for (int j = 0; j < 12; j++) begin
         er = (j == 10) ? 3'b001 : 3'b000;
         step_chk("en_rise0", j, 3'b001, 3'b000, 3'b000, er);
      end

      // release ch0 and press ch2 together, then reset mid-repeat with ch2 held
      ren = 3'b100;
      raw = 3'b100;
      for (int j = 0; j < 27; j++) begin
         reset = ((j == 17) || (j == 18)) ? 1'b0 : 1'b1;
         eo = 3'b000; ed = 3'b000; eu = 3'b000; er = 3'b000;
         if (j < 5) begin
            eo = 3'b001;
         end else if (j == 5) begin
            eo = 3'b100; ed = 3'b100; eu = 3'b001; er = 3'b100;
         end else if (j < 17) begin
            eo = 3'b100;
            er = (j == 15) ? 3'b100 : 3'b000;
         end else if (j == 24) begin
            eo = 3'b100; ed = 3'b100; er = 3'b100;
         end else if (j > 24) begin
            eo = 3'b100;
         end
         step_chk("swap_rst", j, eo, ed, eu, er);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
